// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and the elaboration-time quarter-wave table builder.
package dds_pkg;

    function automatic int amplitude(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int quarter_len(input int aw);
        return 1 << (aw - 2);
    endfunction

    // Taylor series keeps this usable as a constant function on any tool.
    function automatic int quarter_entry(input int dw, input int aw, input int k);
        real x, term, s;
        x = 1.5707963267948966 * k / quarter_len(aw);
        term = x;
        s = x;
        for (int i = 1; i <= 12; i++) begin
            term = -term * x * x / ((2.0 * i) * (2.0 * i + 1.0));
            s = s + term;
        end
        return $rtoi(amplitude(dw) * s + 0.5);
    endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// dds_quarter_lut: quarter-wave sine table with two folded, signed read ports.
module dds_quarter_lut
    import dds_pkg::*;
#(
    parameter int DW = 12,
    parameter int AW = 13
) (
    input  logic        [AW-1:0] addr_a,
    input  logic        [AW-1:0] addr_b,
    output logic signed [DW-1:0] data_a,
    output logic signed [DW-1:0] data_b
);
    localparam int N = quarter_len(AW);

    logic [DW-1:0] q_table [N+1];

    for (genvar k = 0; k <= N; k++) begin : g_tab
        assign q_table[k] = DW'(quarter_entry(DW, AW, k));
    end

    // Odd quadrants mirror the index, the lower half-circle negates.
    function automatic logic signed [DW-1:0] fold(input logic [AW-1:0] a);
        logic [AW-2:0] r, idx;
        logic signed [DW-1:0] mag;
        r = {1'b0, a[AW-3:0]};
        idx = a[AW-2] ? (AW-1)'(N) - r : r;
        mag = $signed(q_table[idx]);
        return a[AW-1] ? -mag : mag;
    endfunction

    assign data_a = fold(addr_a);
    assign data_b = fold(addr_b);

endmodule

// File: rtl/orth_dds.sv
// orth_dds: quadrature DDS, accumulator -> address register -> registered sin/cos.
module orth_dds
    import dds_pkg::*;
#(
    parameter int PW = 32,
    parameter int DW = 12,
    parameter int AW = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [PW-1:0] freq,
    input  logic        [PW-1:0] phase,
    output logic signed [DW-1:0] sin,
    output logic signed [DW-1:0] cos
);
    localparam int N = quarter_len(AW);

    logic        [PW-1:0] acc, sum;
    logic        [AW-1:0] addr_q, addr_c;
    logic signed [DW-1:0] s_val, c_val;

    assign sum = acc + phase;
    assign addr_c = addr_q + AW'(N);

    dds_quarter_lut #(.DW(DW), .AW(AW)) u_lut (
        .addr_a(addr_q),
        .addr_b(addr_c),
        .data_a(s_val),
        .data_b(c_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            addr_q <= '0;
            sin <= '0;
            cos <= '0;
        end else if (en) begin
            acc <= acc + freq;
            addr_q <= sum[PW-1 -: AW];
            sin <= s_val;
            cos <= c_val;
        end
    end

endmodule

// File: tb/tb_orth_dds.sv
// tb_orth_dds: directed self-checking bench for orth_dds.
module tb_orth_dds;
    localparam int PW = 32;
    localparam int DW = 12;
    localparam int AW = 13;
    localparam real PI = 3.14159265358979323846;

    logic                 clk = 0;
    logic                 rst = 1;
    logic                 en = 1;
    logic signed [PW-1:0] freq = '0;
    logic        [PW-1:0] phase = '0;
    logic signed [DW-1:0] s, c;

    int n_checks = 0;
    int n_fail = 0;

    orth_dds #(.PW(PW), .DW(DW), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .freq(freq),
        .phase(phase),
        .sin(s),
        .cos(c)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    function automatic int round_away(input real x);
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    task automatic test_reset();
        en = 1; freq = 32'sh4000_0000; phase = '0; rst = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (s !== 12'sd0 || c !== 12'sd0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: sin=%0d cos=%0d, want 0 0", i, s, c);
            end
        end
        rst = 0;
        step();
        n_checks++;
        if (s !== 12'sd0 || c !== 12'sd2047) begin
            n_fail++;
            $display("FAIL reset release: sin=%0d cos=%0d, want 0 2047", s, c);
        end
    endtask

    task automatic test_quarter();
        int es[9] = '{0, 0, 2047, 0, -2047, 0, 2047, 0, -2047};
        int ec[9] = '{2047, 2047, 0, -2047, 0, 2047, 0, -2047, 0};
        freq = 32'sh4000_0000; phase = '0; en = 1;
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            step();
            n_checks++;
            if (s !== DW'(es[i]) || c !== DW'(ec[i])) begin
                n_fail++;
                $display("FAIL quarter step %0d: sin=%0d cos=%0d, want %0d %0d", i, s, c, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_phase();
        logic [PW-1:0] ph[3] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        int es[3] = '{2047, 0, -2047};
        int ec[3] = '{0, -2047, 0};
        int ps = 0, pc = 2047;
        freq = '0; phase = '0; en = 1;
        pulse_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            phase = ph[i];
            step();
            n_checks++;
            if (s !== DW'(ps) || c !== DW'(pc)) begin
                n_fail++;
                $display("FAIL phase %0d early: sin=%0d cos=%0d, want %0d %0d", i, s, c, ps, pc);
            end
            step();
            n_checks++;
            if (s !== DW'(es[i]) || c !== DW'(ec[i])) begin
                n_fail++;
                $display("FAIL phase %0d: sin=%0d cos=%0d, want %0d %0d", i, s, c, es[i], ec[i]);
            end
            ps = es[i]; pc = ec[i];
        end
    endtask

    task automatic test_reverse_nyquist();
        int rs[6] = '{0, 0, -2047, 0, 2047, 0};
        int rc[6] = '{2047, 2047, 0, -2047, 0, 2047};
        int nc[8] = '{2047, 2047, -2047, 2047, -2047, 2047, -2047, 2047};
        freq = -32'sh4000_0000; phase = '0; en = 1;
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (s !== DW'(rs[i]) || c !== DW'(rc[i])) begin
                n_fail++;
                $display("FAIL reverse step %0d: sin=%0d cos=%0d, want %0d %0d", i, s, c, rs[i], rc[i]);
            end
        end
        freq = 32'sh8000_0000;
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (s !== 12'sd0 || c !== DW'(nc[i])) begin
                n_fail++;
                $display("FAIL nyquist step %0d: sin=%0d cos=%0d, want 0 %0d", i, s, c, nc[i]);
            end
        end
    endtask

    task automatic test_enable();
        int es[3] = '{-2047, 0, 2047};
        int ec[3] = '{0, 2047, 0};
        freq = 32'sh4000_0000; phase = '0; en = 1;
        pulse_reset();
        repeat (4) step();
        en = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (s !== 12'sd0 || c !== -12'sd2047) begin
                n_fail++;
                $display("FAIL enable hold %0d: sin=%0d cos=%0d, want 0 -2047", i, s, c);
            end
        end
        en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (s !== DW'(es[i]) || c !== DW'(ec[i])) begin
                n_fail++;
                $display("FAIL enable resume %0d: sin=%0d cos=%0d, want %0d %0d", i, s, c, es[i], ec[i]);
            end
        end
        en = 0; rst = 1;
        step();
        n_checks++;
        if (s !== 12'sd0 || c !== 12'sd0) begin
            n_fail++;
            $display("FAIL reset priority: sin=%0d cos=%0d, want 0 0", s, c);
        end
        rst = 0; en = 1;
    endtask

    task automatic test_sweep();
        int max_s = -4096, min_s = 4096, max_c = -4096, min_c = 4096;
        int es, ec, p;
        freq = 32'sh0008_0000; phase = '0; en = 1;
        pulse_reset();
        step();
        step();
        for (int i = 0; i < (1 << AW); i++) begin
            es = round_away(2047.0 * $sin(2.0 * PI * i / 8192.0));
            ec = round_away(2047.0 * $cos(2.0 * PI * i / 8192.0));
            n_checks++;
            if (s !== DW'(es) || c !== DW'(ec)) begin
                n_fail++;
                $display("FAIL sweep addr %0d: sin=%0d cos=%0d, want %0d %0d", i, s, c, es, ec);
            end
            p = int'(s) * int'(s) + int'(c) * int'(c) - 2047 * 2047;
            n_checks++;
            if (p > 2 * 2047 || p < -2 * 2047) begin
                n_fail++;
                $display("FAIL sweep norm addr %0d: deviation=%0d, want within +/-4094", i, p);
            end
            max_s = int'(s) > max_s ? int'(s) : max_s;
            min_s = int'(s) < min_s ? int'(s) : min_s;
            max_c = int'(c) > max_c ? int'(c) : max_c;
            min_c = int'(c) < min_c ? int'(c) : min_c;
            step();
        end
        n_checks++;
        if (max_s != 2047 || min_s != -2047 || max_c != 2047 || min_c != -2047) begin
            n_fail++;
            $display("FAIL sweep extremes: sin %0d..%0d cos %0d..%0d, want -2047..2047", min_s, max_s, min_c, max_c);
        end
    endtask

    initial begin
        test_reset();
        test_quarter();
        test_phase();
        test_reverse_nyquist();
        test_enable();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
